// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte blocks.
// Misses are serviced over a block-wide request/response port to data memory.
module data_cache #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_input_valid,
    input  logic [31:0]  addr,
    input  logic         mem_rw,
    input  logic [31:0]  din,
    output logic         is_ready,
    output logic         is_output_valid,
    output logic [31:0]  dout,
    output logic         is_hit,
    output logic         mem_req_valid,
    output logic         mem_req_write,
    output logic [31:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_req_ready,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);
    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS   = 28 - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        FILL_WAIT
    } state_t;

    state_t state, state_next;

    logic [31:2]           req_addr;
    logic                  req_rw;
    logic [31:0]           req_din;
    logic                  miss_flag;
    logic [31:0]           dout_q;

    logic [NUM_SETS-1:0]   valid;
    logic [NUM_SETS-1:0]   dirty;
    logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
    logic [127:0]          data_mem [NUM_SETS];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            word_sel;
    logic                  hit;
    logic [31:0]           sel_word;
    logic                  unused_addr_bits;

    assign idx              = req_addr[4 +: INDEX_BITS];
    assign req_tag          = req_addr[31 -: TAG_BITS];
    assign word_sel         = req_addr[3:2];
    assign hit              = valid[idx] && (tag_mem[idx] == req_tag);
    assign sel_word         = data_mem[idx][{word_sel, 5'b00000} +: 32];
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        state_next      = state;
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_write   = 1'b0;
        mem_req_addr    = '0;
        mem_req_data    = '0;
        case (state)
            IDLE: begin
                // reset forces IDLE, so gating here keeps is_ready low during reset
                is_ready = reset;
                if (is_input_valid) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    is_output_valid = 1'b1;
                    state_next      = IDLE;
                end else if (valid[idx] && dirty[idx]) begin
                    state_next = WRITE_BACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {tag_mem[idx], idx, 4'b0000};
                mem_req_data  = data_mem[idx];
                if (mem_req_ready) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, idx, 4'b0000};
                if (mem_req_ready) state_next = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_resp_valid) state_next = COMPARE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout   = (is_output_valid && !req_rw) ? sel_word : dout_q;
    assign is_hit = is_output_valid && !miss_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_addr  <= '0;
            req_rw    <= 1'b0;
            req_din   <= '0;
            miss_flag <= 1'b0;
            dout_q    <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && is_input_valid) begin
                req_addr  <= addr[31:2];
                req_rw    <= mem_rw;
                req_din   <= din;
                miss_flag <= 1'b0;
            end
            if (state == COMPARE) begin
                if (hit) begin
                    if (req_rw) dirty[idx] <= 1'b1;
                    else        dout_q     <= sel_word;
                end else begin
                    miss_flag <= 1'b1;
                end
            end
            if (state == FILL_WAIT && mem_resp_valid) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // Tag/data arrays carry no reset; writes are gated by states unreachable in reset.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_rw)
            data_mem[idx][{word_sel, 5'b00000} +: 32] <= req_din;
        if (state == FILL_WAIT && mem_resp_valid) begin
            data_mem[idx] <= mem_resp_data;
            tag_mem[idx]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Randomised bench for data_cache: a flat word memory gives expected load data,
// a per-set residency map predicts hits, write-backs and fills.
module tb_data_cache;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         is_input_valid = 1'b0;
    logic [31:0]  addr = '0;
    logic         mem_rw = 1'b0;
    logic [31:0]  din = '0;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         mem_req_valid;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_ready = 1'b0;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;

    data_cache #(.NUM_SETS(16)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_rw(mem_rw), .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid),
        .dout(dout), .is_hit(is_hit), .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Backing memory by block number, architectural memory by word number.
    logic [127:0] bmem [int unsigned];
    logic [31:0]  gold [int unsigned];
    bit           res_valid [16];
    bit           res_dirty [16];
    int unsigned  res_blk   [16];

    function automatic logic [127:0] bmem_rd(input int unsigned blk);
        logic [127:0] b;
        if (bmem.exists(blk)) return bmem[blk];
        for (int unsigned w = 0; w < 4; w++)
            b[w*32 +: 32] = ((blk * 4 + w) * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
        return b;
    endfunction

    function automatic logic [31:0] gold_rd(input int unsigned wa);
        logic [127:0] b;
        if (gold.exists(wa)) return gold[wa];
        b = bmem_rd(wa / 4);
        return b[(wa % 4) * 32 +: 32];
    endfunction

    function automatic logic [127:0] gold_blk(input int unsigned blk);
        logic [127:0] b;
        for (int unsigned w = 0; w < 4; w++) b[w*32 +: 32] = gold_rd(blk * 4 + w);
        return b;
    endfunction

    // Dirty lines are lost on reset: the architectural view reverts to backing memory.
    task automatic model_reset();
        for (int unsigned s = 0; s < 16; s++) begin
            if (res_valid[s] && res_dirty[s])
                for (int unsigned w = 0; w < 4; w++) gold.delete(res_blk[s] * 4 + w);
            res_valid[s] = 0;
            res_dirty[s] = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, is_ready, 0);
        check({tag, "_ov"}, is_output_valid, 0);
        check({tag, "_hit"}, is_hit, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_rv"}, mem_req_valid, 0);
        check({tag, "_rw"}, mem_req_write, 0);
        check({tag, "_ra"}, mem_req_addr, 0);
        check({tag, "_rd"}, mem_req_data, 0);
    endtask

    // One request: wb_stall = minimum refused write-back cycles, lat < 0 = random fill latency.
    task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d,
                          input int wb_stall, input int lat, input bit abort_fill);
        int unsigned blk, set, wa, vblk;
        bit exp_hit, exp_wb, done, wb_first;
        int wb_seen, fill_seen, resp_cnt, stall, done_cyc;
        logic [31:0] wb_a;
        logic [127:0] wb_d;
        blk = a / 16; set = blk % 16; wa = a / 4; vblk = res_blk[set];
        exp_hit = res_valid[set] && (res_blk[set] == blk);
        exp_wb  = !exp_hit && res_valid[set] && res_dirty[set];
        done = 0; wb_first = 1; wb_seen = 0; fill_seen = 0; resp_cnt = -1; stall = 0;
        done_cyc = 0; wb_a = '0; wb_d = '0;

        for (int w = 0; w < 50 && !is_ready; w++) @(negedge clk);
        if (!is_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        is_input_valid = 1; addr = a; mem_rw = rw; din = d;
        @(negedge clk);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            is_input_valid = 1'($urandom % 2);
            addr = $urandom; mem_rw = 1'($urandom % 2); din = $urandom;
            mem_req_ready = 0; mem_resp_valid = 0;
            mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
            check("busy_not_ready", is_ready, 0);
            if (resp_cnt == 0) begin
                mem_resp_valid = 1;
                mem_resp_data  = bmem_rd(blk);
                resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end
            if (is_output_valid) begin
                check("no_req_with_ov", mem_req_valid, 0);
                check("is_hit", is_hit, exp_hit);
                if (!rw) check("dout", dout, gold_rd(wa));
                check("wb_count", wb_seen, exp_wb);
                check("fill_count", fill_seen, !exp_hit);
                done_cyc = cyc;
                done = 1;
            end else if (mem_req_valid) begin
                if (mem_req_write) begin
                    if (wb_first) begin
                        check("wb_addr", mem_req_addr, vblk * 16);
                        check("wb_data", mem_req_data, gold_blk(vblk));
                        wb_a = mem_req_addr; wb_d = mem_req_data; wb_first = 0;
                    end else begin
                        check("wb_addr_stable", mem_req_addr, wb_a);
                        check("wb_data_stable", mem_req_data, wb_d);
                    end
                    check("wb_before_fill", fill_seen, 0);
                    if (stall >= wb_stall && ($urandom % 3) != 0) begin
                        mem_req_ready = 1;
                        wb_seen++;
                        bmem[mem_req_addr / 16] = mem_req_data;
                    end else begin
                        stall++;
                        if (($urandom % 4) == 0) mem_resp_valid = 1;
                    end
                end else begin
                    check("fill_addr", mem_req_addr, blk * 16);
                    check("fill_after_wb", wb_seen, exp_wb);
                    if (($urandom % 2) != 0) begin
                        mem_req_ready = 1;
                        fill_seen++;
                        resp_cnt = (lat < 0) ? int'($urandom % 5) : lat;
                        if (abort_fill) done = 1;
                    end
                end
            end
            if (done) is_input_valid = 0;
            @(negedge clk);
        end
        is_input_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        if (!done) begin
            check("req_timeout", 0, 1);
            return;
        end
        if (abort_fill) return;
        if (exp_hit) check("hit_latency", done_cyc, 0);
        if (!exp_hit) begin
            res_valid[set] = 1; res_blk[set] = blk; res_dirty[set] = 0;
        end
        if (rw) begin
            gold[wa] = d;
            res_dirty[set] = 1;
        end
    endtask

    initial begin
        logic [31:0] ra;
        bmem[32'h10] = {32'h33, 32'h22, 32'h11, 32'h00};
        model_reset();

        #12;
        check_all_zero("in_reset");
        @(negedge clk); reset = 1;
        @(negedge clk);
        check("ready_after_reset", is_ready, 1);

        do_req(32'h100, 0, 0, 0, 3, 0);
        do_req(32'h104, 0, 0, 0, -1, 0);
        do_req(32'h108, 1, 32'hDEADBEEF, 0, -1, 0);
        do_req(32'h108, 0, 0, 0, -1, 0);
        do_req(32'h1100, 0, 0, 5, -1, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom % 4)
                0: ra = 32'h0000_0000;
                1: ra = 32'h0000_0100;
                2: ra = 32'h0000_0200;
                default: ra = 32'h0000_1100;
            endcase
            ra = ra | (32'($urandom % 16) << 4) | (32'($urandom % 4) << 2);
            do_req(ra, 1'($urandom % 2), $urandom, int'($urandom % 3), -1, 0);
        end

        // Abort in FILL_WAIT; the late response must be ignored.
        do_req(32'h2000, 0, 0, 0, 2, 1);
        #1 reset = 0;
        #1 check_all_zero("abort_reset");
        model_reset();
        @(negedge clk);
        check_all_zero("abort_reset_hold");
        reset = 1;
        @(negedge clk);
        mem_resp_valid = 1;
        mem_resp_data  = {4{32'hBAD0BAD0}};
        @(negedge clk);
        mem_resp_valid = 0;
        check("stray_resp_ov", is_output_valid, 0);
        check("stray_resp_ready", is_ready, 1);
        do_req(32'h104, 0, 0, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
